// File: rtl/int_gw_pkg.sv
// Shared definitions for the interrupt gateway / arbiter slice:
// gateway state encoding, the "no source" ID and the claim-ID width helper.
package int_gw_pkg;

    // Gateway state encoding, kept as plain 2-bit constants so that
    // older tools and waveform scripts can decode it directly.
    typedef logic [1:0] gw_state_t;

    localparam gw_state_t GW_IDLE     = 2'd0;
    localparam gw_state_t GW_PENDING  = 2'd1;
    localparam gw_state_t GW_INFLIGHT = 2'd2;

    // ID 0 is reserved to mean "no source offered".
    localparam int NO_ID = 0;

    // Width needed to hold IDs 0..num_src, where 0 is the empty ID.
    function automatic int calc_id_w(input int num_src);
        return $clog2(num_src + 1);
    endfunction

endpackage

// File: rtl/int_gateway_arbiter_if.sv
// Claim/complete handshake between the interrupt arbiter and the
// hart-side consumer (the trap handler's claim/complete path).
interface int_gateway_arbiter_if #(
    parameter int ID_W = 2
);

    logic            claim_valid;
    logic            claim_ready;
    logic [ID_W-1:0] claim_id;
    logic            complete_valid;
    logic [ID_W-1:0] complete_id;

    // Arbiter side: offers claims, receives acceptances and completions.
    modport master (
        output claim_valid,
        output claim_id,
        input  claim_ready,
        input  complete_valid,
        input  complete_id
    );

    // Consumer side: accepts claims and reports completions.
    modport slave (
        input  claim_valid,
        input  claim_id,
        output claim_ready,
        output complete_valid,
        output complete_id
    );

endinterface

// File: rtl/int_gw_source.sv
// One interrupt gateway: latches a level interrupt as pending, locks it out
// while the handler owns it, and reports whether it may compete for a claim.
module int_gw_source
    import int_gw_pkg::*;
#(
    parameter int PRIO_W = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_int_q,
    input  logic              i_claim_hit,
    input  logic              i_complete_hit,
    input  logic              i_enable,
    input  logic [PRIO_W-1:0] i_prio,
    input  logic [PRIO_W-1:0] i_threshold,
    output gw_state_t         o_state,
    output logic              o_eligible
);

    gw_state_t r_state;
    gw_state_t w_state_nxt;

    // Next-state logic. A pending request is never retracted when the line
    // drops, and an in-flight source ignores its line until it is completed;
    // a completion arriving while still pending (same-cycle claim) is ignored.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            GW_IDLE: begin
                if (i_int_q) begin
                    w_state_nxt = GW_PENDING;
                end
            end
            GW_PENDING: begin
                if (i_claim_hit) begin
                    w_state_nxt = GW_INFLIGHT;
                end
            end
            GW_INFLIGHT: begin
                if (i_complete_hit) begin
                    w_state_nxt = GW_IDLE;
                end
            end
            default: begin
                w_state_nxt = GW_IDLE;
            end
        endcase
    end

    // State register; reset drops any pending or in-flight request.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= GW_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Enable and threshold only gate competition, never the latching itself,
    // so a source disabled while pending becomes visible again when enabled.
    // Priority 0 can never exceed any threshold, so it is never eligible.
    assign o_eligible = (r_state == GW_PENDING) && i_enable && (i_prio > i_threshold);
    assign o_state    = r_state;

endmodule

// File: rtl/int_gateway_arbiter.sv
// Interrupt gateway array plus priority arbiter. Registers the incoming
// level lines, runs one gateway per source, picks the highest-priority
// eligible source and holds it as a stable claim offer until accepted.
module int_gateway_arbiter
    import int_gw_pkg::*;
#(
    parameter  int NUM_SRC = 2,
    parameter  int PRIO_W  = 3,
    localparam int ID_W    = calc_id_w(NUM_SRC)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_SRC-1:0]        int_in,
    input  logic [NUM_SRC-1:0]        src_enable,
    input  logic [NUM_SRC*PRIO_W-1:0] src_prio,
    input  logic [PRIO_W-1:0]         threshold,
    output logic                      irq,
    int_gateway_arbiter_if.master     bus
);

    logic [NUM_SRC-1:0] r_int_q;
    logic               r_claim_valid;
    logic [ID_W-1:0]    r_claim_id;

    logic [PRIO_W-1:0]  w_prio [NUM_SRC];
    gw_state_t          w_state [NUM_SRC];
    logic [NUM_SRC-1:0] w_eligible;
    logic [NUM_SRC-1:0] w_claim_hit;
    logic [NUM_SRC-1:0] w_complete_hit;
    logic               w_claim_fire;

    logic               w_win_valid;
    logic [ID_W-1:0]    w_win_id;
    logic [PRIO_W-1:0]  w_win_prio;

    // Single register stage on the already-synchronized level lines; the
    // sources are level-triggered so no edge detection or filtering is done.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_int_q <= '0;
        end else begin
            r_int_q <= int_in;
        end
    end

    assign w_claim_fire = r_claim_valid && bus.claim_ready;

    genvar g;
    generate
        for (g = 0; g < NUM_SRC; g++) begin : g_src
            assign w_prio[g] = src_prio[g*PRIO_W +: PRIO_W];

            // Only the source named by the accepted offer moves to in-flight.
            // The offered source is always pending; the state qualifier keeps
            // that invariant local rather than relying on the offer register.
            assign w_claim_hit[g] = w_claim_fire
                                 && (r_claim_id == ID_W'(g + 1))
                                 && (w_state[g] == GW_PENDING);

            // IDs 0 and above NUM_SRC never match any gateway, so illegal
            // completions fall through without touching any state.
            assign w_complete_hit[g] = bus.complete_valid
                                    && (bus.complete_id == ID_W'(g + 1));

            int_gw_source #(
                .PRIO_W (PRIO_W)
            ) u_src (
                .clock          (clock),
                .reset          (reset),
                .i_int_q        (r_int_q[g]),
                .i_claim_hit    (w_claim_hit[g]),
                .i_complete_hit (w_complete_hit[g]),
                .i_enable       (src_enable[g]),
                .i_prio         (w_prio[g]),
                .i_threshold    (threshold),
                .o_state        (w_state[g]),
                .o_eligible     (w_eligible[g])
            );
        end
    endgenerate

    // Winner search: strictly-greater comparison while scanning upward in ID
    // means equal priorities resolve to the lowest ID. No winner gives ID 0.
    always_comb begin
        w_win_valid = 1'b0;
        w_win_id    = ID_W'(NO_ID);
        w_win_prio  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_eligible[i] && (!w_win_valid || (w_prio[i] > w_win_prio))) begin
                w_win_valid = 1'b1;
                w_win_id    = ID_W'(i + 1);
                w_win_prio  = w_prio[i];
            end
        end
    end

    // Offer register. A live offer is frozen until accepted: a later,
    // higher-priority arrival or a config change must not swap the ID under
    // a handler that may already be reading it. After acceptance the offer
    // drops for one cycle so the winner is recomputed from updated state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_claim_valid <= 1'b0;
            r_claim_id    <= ID_W'(NO_ID);
        end else if (r_claim_valid) begin
            if (bus.claim_ready) begin
                r_claim_valid <= 1'b0;
                r_claim_id    <= ID_W'(NO_ID);
            end
        end else begin
            r_claim_valid <= w_win_valid;
            r_claim_id    <= w_win_id;
        end
    end

    assign bus.claim_valid = r_claim_valid;
    assign bus.claim_id    = r_claim_id;

    // irq follows eligibility directly so the core sees it as soon as a
    // source is pending and passes enable/threshold, ahead of the offer.
    assign irq = |w_eligible;

endmodule

// File: tb/tb_int_gateway_arbiter.sv
// Self-checking bench for int_gateway_arbiter: directed scenarios with
// constant expectations, then randomized traffic checked each cycle against
// a behavioural model kept as per-source pending/busy flags and an offer ID.
module tb_int_gateway_arbiter;

    localparam int NUM_SRC = 2;
    localparam int PRIO_W  = 3;
    localparam int ID_W    = 2;

    logic                      clock = 1'b0;
    logic                      reset = 1'b0;
    logic [NUM_SRC-1:0]        int_in;
    logic [NUM_SRC-1:0]        src_enable;
    logic [NUM_SRC*PRIO_W-1:0] src_prio;
    logic [PRIO_W-1:0]         threshold;
    logic                      irq;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    bit m_intq [NUM_SRC];
    bit m_pend [NUM_SRC];
    bit m_busy [NUM_SRC];
    int m_offer;

    int_gateway_arbiter_if #(.ID_W(ID_W)) bus ();

    int_gateway_arbiter #(
        .NUM_SRC (NUM_SRC),
        .PRIO_W  (PRIO_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .int_in     (int_in),
        .src_enable (src_enable),
        .src_prio   (src_prio),
        .threshold  (threshold),
        .irq        (irq),
        .bus        (bus)
    );

    always #5 clock = ~clock;

    function automatic int prio_of(input int i);
        return int'(src_prio[i*PRIO_W +: PRIO_W]);
    endfunction

    function automatic bit model_elig(input int i);
        return m_pend[i] && src_enable[i] && (prio_of(i) > int'(threshold));
    endfunction

    function automatic bit model_irq();
        bit any = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) any |= model_elig(i);
        return any;
    endfunction

    // Highest priority wins; scanning upward with strict > keeps lowest ID on ties
    function automatic int model_best();
        int best = 0;
        int bp   = -1;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (model_elig(i) && prio_of(i) > bp) begin
                best = i + 1;
                bp   = prio_of(i);
            end
        end
        return best;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NUM_SRC; i++) begin
            m_intq[i] = 1'b0;
            m_pend[i] = 1'b0;
            m_busy[i] = 1'b0;
        end
        m_offer = 0;
    endtask

    task automatic model_step();
        bit fire;
        int nxt_offer;
        fire = (m_offer != 0) && bus.claim_ready;
        if (m_offer != 0) nxt_offer = bus.claim_ready ? 0 : m_offer;
        else              nxt_offer = model_best();
        for (int i = 0; i < NUM_SRC; i++) begin
            if (m_busy[i]) begin
                if (bus.complete_valid && int'(bus.complete_id) == i + 1) m_busy[i] = 1'b0;
            end else if (m_pend[i]) begin
                if (fire && m_offer == i + 1) begin
                    m_pend[i] = 1'b0;
                    m_busy[i] = 1'b1;
                end
            end else if (m_intq[i]) begin
                m_pend[i] = 1'b1;
            end
        end
        m_offer = nxt_offer;
        for (int i = 0; i < NUM_SRC; i++) m_intq[i] = int_in[i];
    endtask

    // One clock edge; the model advances on the same edge, outputs sampled 1ns later
    task automatic tick();
        @(posedge clock);
        if (!reset) model_clear();
        else        model_step();
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic set_prio(input int p1, input int p2);
        src_prio = {PRIO_W'(p2), PRIO_W'(p1)};
    endtask

    task automatic do_reset();
        reset              = 1'b0;
        int_in             = '0;
        bus.claim_ready    = 1'b0;
        bus.complete_valid = 1'b0;
        bus.complete_id    = '0;
        model_clear();
        #1;
        tick_n(2);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        src_enable = 2'b11;
        set_prio(3, 0);
        threshold  = '0;
        do_reset();
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %b want 0", irq); end
        vectors++; if (bus.claim_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", bus.claim_valid); end
        vectors++; if (bus.claim_id !== 2'd0) begin miscompares++; $display("FAIL reset_id: got %0d want 0", bus.claim_id); end
    endtask

    task automatic test_single();
        do_reset();
        src_enable = 2'b11; set_prio(3, 0); threshold = '0;
        int_in = 2'b01;
        tick();
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL single_irq_e0: got %b want 0", irq); end
        tick();
        vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL single_irq_e1: got %b want 1", irq); end
        vectors++; if (bus.claim_valid !== 1'b0) begin miscompares++; $display("FAIL single_valid_e1: got %b want 0", bus.claim_valid); end
        tick();
        vectors++; if (bus.claim_valid !== 1'b1 || bus.claim_id !== 2'd1) begin
            miscompares++; $display("FAIL single_offer_e2: got v=%b id=%0d want v=1 id=1", bus.claim_valid, bus.claim_id); end
        bus.claim_ready = 1'b1;
        tick();
        bus.claim_ready = 1'b0;
        vectors++; if (bus.claim_valid !== 1'b0 || irq !== 1'b0) begin
            miscompares++; $display("FAIL single_claimed_e3: got v=%b irq=%b want v=0 irq=0", bus.claim_valid, irq); end
    endtask

    task automatic test_retrigger();
        bus.complete_valid = 1'b1; bus.complete_id = 2'd1;
        tick();
        bus.complete_valid = 1'b0;
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL retrig_idle: got irq=%b want 0", irq); end
        tick();
        vectors++; if (irq !== 1'b1 || bus.claim_valid !== 1'b0) begin
            miscompares++; $display("FAIL retrig_pending: got irq=%b v=%b want irq=1 v=0", irq, bus.claim_valid); end
        tick();
        vectors++; if (bus.claim_valid !== 1'b1 || bus.claim_id !== 2'd1) begin
            miscompares++; $display("FAIL retrig_offer: got v=%b id=%0d want v=1 id=1", bus.claim_valid, bus.claim_id); end
        bus.claim_ready = 1'b1;
        tick();
        bus.claim_ready = 1'b0;
        int_in = 2'b00;
        tick();
        bus.complete_valid = 1'b1; bus.complete_id = 2'd1;
        tick();
        bus.complete_valid = 1'b0;
        tick_n(2);
        vectors++; if (irq !== 1'b0 || bus.claim_valid !== 1'b0) begin
            miscompares++; $display("FAIL retrig_low_line: got irq=%b v=%b want irq=0 v=0", irq, bus.claim_valid); end
    endtask

    task automatic test_priority();
        do_reset();
        src_enable = 2'b11; set_prio(2, 5); threshold = '0;
        int_in = 2'b11;
        tick_n(3);
        vectors++; if (bus.claim_valid !== 1'b1 || bus.claim_id !== 2'd2) begin
            miscompares++; $display("FAIL prio_first: got v=%b id=%0d want v=1 id=2", bus.claim_valid, bus.claim_id); end
        bus.claim_ready = 1'b1;
        tick();
        bus.claim_ready = 1'b0;
        vectors++; if (bus.claim_valid !== 1'b0) begin miscompares++; $display("FAIL prio_bubble: got v=%b want 0", bus.claim_valid); end
        tick();
        vectors++; if (bus.claim_valid !== 1'b1 || bus.claim_id !== 2'd1) begin
            miscompares++; $display("FAIL prio_second: got v=%b id=%0d want v=1 id=1", bus.claim_valid, bus.claim_id); end
        do_reset();
        set_prio(4, 4);
        int_in = 2'b11;
        tick_n(3);
        vectors++; if (bus.claim_valid !== 1'b1 || bus.claim_id !== 2'd1) begin
            miscompares++; $display("FAIL prio_tie: got v=%b id=%0d want v=1 id=1", bus.claim_valid, bus.claim_id); end
    endtask

    task automatic test_gating();
        do_reset();
        src_enable = 2'b11; set_prio(0, 5); threshold = 3'd5;
        int_in = 2'b10;
        tick_n(4);
        vectors++; if (irq !== 1'b0 || bus.claim_valid !== 1'b0) begin
            miscompares++; $display("FAIL thr_block: got irq=%b v=%b want irq=0 v=0", irq, bus.claim_valid); end
        threshold = 3'd4;
        #1;
        vectors++; if (irq !== 1'b1 || bus.claim_valid !== 1'b0) begin
            miscompares++; $display("FAIL thr_lower_irq: got irq=%b v=%b want irq=1 v=0", irq, bus.claim_valid); end
        tick();
        vectors++; if (bus.claim_valid !== 1'b1 || bus.claim_id !== 2'd2) begin
            miscompares++; $display("FAIL thr_offer: got v=%b id=%0d want v=1 id=2", bus.claim_valid, bus.claim_id); end
        do_reset();
        threshold = '0; src_enable = 2'b01; set_prio(0, 5);
        int_in = 2'b10;
        for (int k = 0; k < 5; k++) begin
            tick();
            vectors++; if (bus.claim_valid !== 1'b0 || irq !== 1'b0) begin
                miscompares++; $display("FAIL en_block: cycle %0d got v=%b irq=%b want v=0 irq=0", k, bus.claim_valid, irq); end
        end
        src_enable = 2'b11;
        tick();
        vectors++; if (bus.claim_valid !== 1'b1 || bus.claim_id !== 2'd2) begin
            miscompares++; $display("FAIL en_offer: got v=%b id=%0d want v=1 id=2", bus.claim_valid, bus.claim_id); end
        src_enable = 2'b01; threshold = 3'd7;
        tick_n(2);
        vectors++; if (bus.claim_valid !== 1'b1 || bus.claim_id !== 2'd2) begin
            miscompares++; $display("FAIL en_held_offer: got v=%b id=%0d want v=1 id=2", bus.claim_valid, bus.claim_id); end
    endtask

    task automatic test_stability();
        do_reset();
        src_enable = 2'b11; set_prio(2, 7); threshold = '0;
        int_in = 2'b01;
        tick_n(3);
        int_in = 2'b11;
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++; if (bus.claim_valid !== 1'b1 || bus.claim_id !== 2'd1) begin
                miscompares++; $display("FAIL stable_hold: cycle %0d got v=%b id=%0d want v=1 id=1", k, bus.claim_valid, bus.claim_id); end
        end
        bus.claim_ready = 1'b1;
        tick();
        bus.claim_ready = 1'b0;
        tick();
        vectors++; if (bus.claim_valid !== 1'b1 || bus.claim_id !== 2'd2) begin
            miscompares++; $display("FAIL stable_next: got v=%b id=%0d want v=1 id=2", bus.claim_valid, bus.claim_id); end
    endtask

    task automatic test_illegal();
        int bad_ids [3];
        bad_ids = '{0, 3, 2};
        do_reset();
        src_enable = 2'b11; set_prio(3, 0); threshold = '0;
        int_in = 2'b01;
        tick_n(3);
        bus.claim_ready = 1'b1;
        bus.complete_valid = 1'b1; bus.complete_id = 2'd1;
        tick();
        bus.claim_ready = 1'b0; bus.complete_valid = 1'b0;
        tick_n(2);
        vectors++; if (irq !== 1'b0 || bus.claim_valid !== 1'b0) begin
            miscompares++; $display("FAIL same_cycle_complete: got irq=%b v=%b want irq=0 v=0", irq, bus.claim_valid); end
        foreach (bad_ids[j]) begin
            bus.complete_valid = 1'b1; bus.complete_id = ID_W'(bad_ids[j]);
            tick();
            bus.complete_valid = 1'b0;
            tick();
            vectors++; if (irq !== 1'b0 || bus.claim_valid !== 1'b0) begin
                miscompares++; $display("FAIL illegal_complete_%0d: got irq=%b v=%b want irq=0 v=0", bad_ids[j], irq, bus.claim_valid); end
        end
        bus.complete_valid = 1'b1; bus.complete_id = 2'd1;
        tick();
        bus.complete_valid = 1'b0;
        tick();
        vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL legal_complete: got irq=%b want 1", irq); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        src_enable = 2'b11; set_prio(3, 3); threshold = '0;
        int_in = 2'b11;
        tick_n(3);
        bus.claim_ready = 1'b1;
        tick();
        bus.claim_ready = 1'b0;
        tick();
        vectors++; if (bus.claim_valid !== 1'b1 || bus.claim_id !== 2'd2) begin
            miscompares++; $display("FAIL midrst_pre: got v=%b id=%0d want v=1 id=2", bus.claim_valid, bus.claim_id); end
        reset = 1'b0;
        model_clear();
        #1;
        vectors++; if (irq !== 1'b0 || bus.claim_valid !== 1'b0 || bus.claim_id !== 2'd0) begin
            miscompares++; $display("FAIL midrst_async: got irq=%b v=%b id=%0d want 0 0 0", irq, bus.claim_valid, bus.claim_id); end
        int_in = 2'b01;
        tick_n(2);
        reset = 1'b1;
        tick_n(2);
        vectors++; if (bus.claim_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_early: got v=%b want 0", bus.claim_valid); end
        tick();
        vectors++; if (bus.claim_valid !== 1'b1 || bus.claim_id !== 2'd1) begin
            miscompares++; $display("FAIL midrst_reoffer: got v=%b id=%0d want v=1 id=1", bus.claim_valid, bus.claim_id); end
    endtask

    task automatic test_random();
        do_reset();
        src_enable = 2'b11; set_prio(3, 5); threshold = '0;
        for (int c = 0; c < 600; c++) begin
            if (c == 300) begin
                reset = 1'b0;
                model_clear();
                tick();
                reset = 1'b1;
            end
            int_in = NUM_SRC'($urandom);
            if ($urandom_range(0, 15) == 0) src_enable = NUM_SRC'($urandom);
            if ($urandom_range(0, 15) == 0) src_prio   = (NUM_SRC*PRIO_W)'($urandom);
            if ($urandom_range(0, 15) == 0) threshold  = PRIO_W'($urandom_range(0, 3));
            bus.claim_ready    = 1'($urandom_range(0, 1));
            bus.complete_valid = ($urandom_range(0, 2) == 0);
            bus.complete_id    = ID_W'($urandom);
            tick();
            vectors++; if (irq !== model_irq()) begin
                miscompares++; $display("FAIL rand_irq: cycle %0d got %b want %b", c, irq, model_irq()); end
            vectors++; if (bus.claim_valid !== (m_offer != 0)) begin
                miscompares++; $display("FAIL rand_valid: cycle %0d got %b want %b", c, bus.claim_valid, (m_offer != 0)); end
            vectors++; if (bus.claim_id !== ID_W'(m_offer)) begin
                miscompares++; $display("FAIL rand_id: cycle %0d got %0d want %0d", c, bus.claim_id, m_offer); end
        end
        bus.claim_ready = 1'b0;
        bus.complete_valid = 1'b0;
    endtask

    initial begin
        int_in = '0; src_enable = '0; src_prio = '0; threshold = '0;
        bus.claim_ready = 1'b0; bus.complete_valid = 1'b0; bus.complete_id = '0;
        model_clear();
        test_reset();
        test_single();
        test_retrigger();
        test_priority();
        test_gating();
        test_stability();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
